// File: rtl/ram_dumper.sv
// ram_dumper: reads a contiguous RAM range and streams each word LSB-first as bytes over valid/ready.
// Optional XOR checksum trailer byte when RAM_DUMPER_CHECKSUM_EN is defined.
module ram_dumper #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [WIDTH-1:0]      ram_dout,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready
);
   localparam int NBYTES = (WIDTH + 7) / 8;
   localparam int SW     = NBYTES * 8;
   localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   WORDS_ONE = 1;
   localparam logic [BCW-1:0]        BCNT_ONE  = 1;
   localparam logic [BCW-1:0]        BCNT_LAST = BCW'(NBYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
`ifdef RAM_DUMPER_CHECKSUM_EN
      S_CSUM,
`endif
      S_SEND
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic [SW-1:0]         shreg_q, shreg_d;
   logic [BCW-1:0]        bcnt_q, bcnt_d;
   logic                  done_q, done_d;
`ifdef RAM_DUMPER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   logic last_byte, last_word;
   assign last_byte = (bcnt_q == '0);
   assign last_word = (words_q == WORDS_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         words_q <= '0;
         shreg_q <= '0;
         bcnt_q  <= '0;
         done_q  <= 1'b0;
`ifdef RAM_DUMPER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         words_q <= words_d;
         shreg_q <= shreg_d;
         bcnt_q  <= bcnt_d;
         done_q  <= done_d;
`ifdef RAM_DUMPER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && len != '0) state_d = S_FETCH;
         S_FETCH: state_d = S_LOAD;
         S_LOAD:  state_d = S_SEND;
         S_SEND:
            if (tx_ready && last_byte) begin
`ifdef RAM_DUMPER_CHECKSUM_EN
               state_d = last_word ? S_CSUM : S_FETCH;
`else
               state_d = last_word ? S_IDLE : S_FETCH;
`endif
            end
`ifdef RAM_DUMPER_CHECKSUM_EN
         S_CSUM:  if (tx_ready) state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: counters, address, shift register and completion pulse.
   always_comb begin
      addr_d  = addr_q;
      words_d = words_q;
      shreg_d = shreg_q;
      bcnt_d  = bcnt_q;
      done_d  = 1'b0;
`ifdef RAM_DUMPER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE:
            if (start) begin
               addr_d  = base;
               words_d = len;
               done_d  = (len == '0);
`ifdef RAM_DUMPER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         S_LOAD: begin
            shreg_d = SW'(ram_dout);
            bcnt_d  = BCNT_LAST;
         end
         S_SEND:
            if (tx_ready) begin
               shreg_d = shreg_q >> 8;
`ifdef RAM_DUMPER_CHECKSUM_EN
               csum_d  = csum_q ^ shreg_q[7:0];
`endif
               if (!last_byte) begin
                  bcnt_d = bcnt_q - BCNT_ONE;
               end else begin
                  words_d = words_q - WORDS_ONE;
                  addr_d  = addr_q + ADDR_ONE;
`ifndef RAM_DUMPER_CHECKSUM_EN
                  done_d  = last_word;
`endif
               end
            end
`ifdef RAM_DUMPER_CHECKSUM_EN
         S_CSUM: if (tx_ready) done_d = 1'b1;
`endif
         default: ;
      endcase
   end

   // Outputs depend only on registered state, so they hold steady during a stall.
   always_comb begin
      busy     = (state_q != S_IDLE);
      tx_valid = 1'b0;
      tx_data  = '0;
      case (state_q)
         S_SEND: begin
            tx_valid = 1'b1;
            tx_data  = shreg_q[7:0];
         end
`ifdef RAM_DUMPER_CHECKSUM_EN
         S_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
         end
`endif
         default: ;
      endcase
   end

   assign done     = done_q;
   assign ram_addr = addr_q;

endmodule

// File: tb/tb_ram_dumper.sv
// Directed bench for ram_dumper with a synchronous-read RAM model and a byte-stream monitor.
module tb_ram_dumper;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base = '0;
   logic [8:0]  len = '0;
   logic        busy, done, tx_valid;
   logic [7:0]  ram_addr, tx_data;
   logic [15:0] ram_dout;
   logic        tx_ready;

   logic [15:0] mem [256];
   logic [7:0]  got [$];
   logic [7:0]  exp_q [$];
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, last_hs = -1, stall_err = 0;
   logic        vld_seen = 1'b0, stalled = 1'b0;
   logic [7:0]  stall_data = '0;
   logic        rdy_toggle = 1'b0, rdy_fixed = 1'b1;
   logic [3:0]  pat = 4'b1001;
   int          pidx = 0;

   ram_dumper #(.WIDTH(16), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
      .busy(busy), .done(done), .ram_addr(ram_addr), .ram_dout(ram_dout),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk) ram_dout <= mem[ram_addr];

   always @(posedge clk) begin
      #1;
      if (rdy_toggle) begin
         tx_ready = pat[pidx];
         pidx = (pidx + 1) % 4;
      end else begin
         tx_ready = rdy_fixed;
      end
   end

   // Handshakes seen at the negedge complete on the following rising edge.
   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         got.push_back(tx_data);
         last_hs = cyc + 1;
      end
      if (tx_valid) vld_seen = 1'b1;
      if (stalled && (tx_valid !== 1'b1 || tx_data !== stall_data)) stall_err++;
      stalled    = tx_valid && !tx_ready;
      stall_data = tx_data;
   end

   task automatic check(input string tag, input int got_v, input int exp_v);
      n_chk++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   task automatic dump(input logic [7:0] b, input logic [8:0] l, output int n_edge,
                       output int first_vld, output logic busy1, output int done_cyc);
      got.delete();
      vld_seen = 1'b0;
      @(posedge clk); #1;
      base = b; len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_edge = cyc;
      busy1 = busy;
      first_vld = -1;
      done_cyc = -1;
      for (int k = 0; k < 2000; k++) begin
         if (tx_valid && first_vld < 0) first_vld = cyc - n_edge;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic cmp_stream(input string tag);
`ifdef RAM_DUMPER_CHECKSUM_EN
      logic [7:0] x;
      x = '0;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
`endif
      check({tag, "_nbytes"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), (i < got.size()) ? int'(got[i]) : -1, int'(exp_q[i]));
   endtask

   initial begin
      int   n_edge, first_vld, done_cyc;
      logic busy1;

      foreach (mem[i]) mem[i] = 16'(i * 3 + 1);
      mem[8'h10] = 16'hBEEF;
      mem[8'h11] = 16'h1234;
      mem[8'hFF] = 16'hA55A;
      mem[8'h00] = 16'h0F1E;

      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_txdata", tx_data, 0);
      check("rst_txvalid", tx_valid, 0);
      @(negedge clk); rst_n = 1'b1;

      // Basic two-word dump, consumer always ready.
      dump(8'h10, 9'd2, n_edge, first_vld, busy1, done_cyc);
      check("t1_busy_n1", busy1, 1);
      check("t1_first_valid", first_vld, 2);
      check("t1_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
      check("t1_done_timing", done_cyc, last_hs);
      check("t1_busy_at_done", busy, 0);
      @(posedge clk); #1;
      check("t1_done_one_cycle", done, 0);
      exp_q = '{8'hEF, 8'hBE, 8'h34, 8'h12};
      cmp_stream("t1");

      // Same dump with a stalling consumer.
      stall_err = 0;
      pidx = 0;
      rdy_toggle = 1'b1;
      dump(8'h10, 9'd2, n_edge, first_vld, busy1, done_cyc);
      rdy_toggle = 1'b0;
      check("t2_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
      check("t2_done_timing", done_cyc, last_hs);
      check("t2_stall_stable", stall_err, 0);
      exp_q = '{8'hEF, 8'hBE, 8'h34, 8'h12};
      cmp_stream("t2");

      // Address wrap from 0xFF to 0x00.
      dump(8'hFF, 9'd2, n_edge, first_vld, busy1, done_cyc);
      check("t3_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
      check("t3_addr_end", ram_addr, 8'h01);
      exp_q = '{8'h5A, 8'hA5, 8'h1E, 8'h0F};
      cmp_stream("t3");

      // Zero-length request.
      dump(8'h20, 9'd0, n_edge, first_vld, busy1, done_cyc);
      check("t4_done_n1", done_cyc - n_edge, 0);
      check("t4_busy", busy1, 0);
      @(posedge clk); #1;
      check("t4_done_one_cycle", done, 0);
      repeat (4) @(posedge clk);
      #1;
      check("t4_no_valid", vld_seen, 0);
      check("t4_nbytes", got.size(), 0);

      // Reset while the second byte of a word is on the bus.
      got.delete();
      @(posedge clk); #1;
      base = 8'h10; len = 9'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (got.size() >= 1 && tx_valid) break;
         @(posedge clk); #1;
      end
      check("t5_second_byte", tx_data, 8'hBE);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_addr", ram_addr, 0);
      check("t5_rst_txdata", tx_data, 0);
      check("t5_rst_txvalid", tx_valid, 0);
      @(negedge clk); rst_n = 1'b1;
      dump(8'h10, 9'd1, n_edge, first_vld, busy1, done_cyc);
      check("t5_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
      exp_q = '{8'hEF, 8'hBE};
      cmp_stream("t5");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_dumper.md
# ram_dumper

Sequential RAM reader: on a start request, reads a contiguous range of words from the banked `ram` block and serializes each word as a little-endian byte stream over a valid/ready interface. It sits between the data RAM's read port and the UART transmitter, and is used for memory dumps and debug readback on the icestick board. It is the read-side counterpart of the RAM write path and never asserts a write.

## Interface
Parameters:
- `WIDTH`, 16: RAM word width in bits; must match the attached RAM.
- `ADDR_WIDTH`, 8: RAM address width in bits; must match the attached RAM.
- Derived: `NBYTES = (WIDTH + 7) / 8`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `base`  in  ADDR_WIDTH  first word address; latched on accepted `start`.
- `len`  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH; latched on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the dump completes.
- `done`  out  1  one-cycle completion pulse.
- `ram_addr`  out  ADDR_WIDTH  RAM read address; registered.
- `ram_dout`  in  WIDTH  RAM read data, valid one cycle after `ram_addr` changes.
- `tx_data`  out  8  current byte.
- `tx_valid`  out  1  byte available.
- `tx_ready`  in  1  consumer accepts the byte when `tx_valid && tx_ready`.

## Operation
- FSM states: IDLE, FETCH, LOAD, SEND, CSUM (CSUM exists only with the macro).
- IDLE: on `start`, latch `base` into `ram_addr` and `len` into the remaining-word counter. If `len == 0`, pulse `done` on the next cycle and stay in IDLE. Otherwise go to FETCH.
- FETCH: `ram_addr` is stable; wait one cycle for the RAM read latency. Go to LOAD.
- LOAD: capture `ram_dout` zero-extended to `NBYTES*8` bits into the shift register, set the byte counter to `NBYTES-1`, then go to SEND.
- SEND: `tx_valid = 1`, and `tx_data` is the low byte of the shift register. On each handshake:
  - shift right by 8 bits;
  - if bytes remain, stay in SEND;
  - after the last byte of the word, decrement the word counter and increment `ram_addr` (modulo 2^ADDR_WIDTH);
  - if words remain, go to FETCH; otherwise go to CSUM (macro on) or IDLE with a `done` pulse.
- Byte order: least-significant byte first. Pad bits above `WIDTH` in the top byte are 0.
- Address wrap: `base + len` beyond 2^ADDR_WIDTH wraps to address 0. `len = 2^ADDR_WIDTH` dumps the whole RAM exactly once.
- `start` is ignored outside IDLE. `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE.
- `tx_data` and `tx_valid` must not change while `tx_valid && !tx_ready`.
- Reset (at any time, including mid-dump) forces IDLE and clears all outputs. Partially sent words are discarded; there is no resume.

## Timing
- Reset values: `busy = 0`, `done = 0`, `ram_addr = 0`, `tx_data = 0`, `tx_valid = 0`.
- `start` accepted at edge N:
  - `busy` and FETCH begin in cycle N+1;
  - LOAD in cycle N+2;
  - `tx_valid` rises in cycle N+3.
- Per word with `tx_ready` held high: NBYTES + 2 cycles.
- Final handshake at edge M: `done = 1` and `busy = 0` in cycle M+1 for exactly one cycle.
- `len == 0`: `done` pulses in cycle N+1, and `busy` stays 0.

## Configuration
- `RAM_DUMPER_CHECKSUM_EN` defined:
  - after the last data byte, CSUM emits one extra byte equal to the XOR of all data bytes sent in this dump, under the same handshake rule;
  - `done` follows that byte's handshake;
  - the checksum accumulator clears on each accepted `start`;
  - with `len == 0`, no checksum byte is sent.
- Not defined: no CSUM state, no accumulator, and the stream contains data bytes only.

## Test plan
- WIDTH=16, RAM[0x10]=0xBEEF, RAM[0x11]=0x1234, `start` with base=0x10, len=2, `tx_ready` always high -> bytes EF, BE, 34, 12; first `tx_valid` 3 cycles after start; `done` one cycle after the byte 12 handshake.
- Same dump with `tx_ready` toggling 1,0,0,1,… -> identical byte sequence; `tx_data` stable while stalled; no byte duplicated or lost.
- base=0xFF, len=2 -> reads addresses 0xFF then 0x00 (wrap); `ram_addr` never goes out of range.
- len=0 -> `done` pulses in cycle N+1, `tx_valid` never asserted, `busy` stays 0.
- `rst_n` pulled low in the middle of the second byte of a word -> all outputs are at reset values immediately; a following start with base=0x10, len=1 produces EF, BE.
- With `RAM_DUMPER_CHECKSUM_EN`, base=0x10, len=2 -> EF, BE, 34, 12, then 0x77 (EF^BE^34^12); `done` follows the 0x77 handshake.
